host_launcher: RTL
==================

Name: host_launcher

Overview:
- Synthesizable initiator for the core's Start/Ack launch handshake.
- Plays the role the bench plays today: preloads operand bytes into data memory through a write port, parks the core with Start high, then releases Start to launch the program.
- Waits for Ack, then reads result bytes back from data memory.
- Sits beside TopLevel on an FPGA/SoC harness and shares the data-memory port with it.

Parameters:
- NUM_IN, 4, operand bytes written per run
- NUM_OUT, 4, result bytes read per run
- IN_BASE, 1, DM address of the first operand byte (MSB first)
- OUT_BASE, 5, DM address of the first result byte (MSB first)
- ADDR_W, 8, DM address width
- TIMEOUT, 1024, WAIT_ACK cycle limit (used only with the optional feature)

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Go  in  1  one-cycle request to start a run
- LoadData  in  NUM_IN*8  operand bytes; bits [NUM_IN*8-1 -: 8] go to IN_BASE
- DmAddr  out  ADDR_W  DM address
- DmWrData  out  8  DM write data
- DmWrEn  out  1  DM write strobe
- DmRdData  in  8  DM read data; combinational, valid in the same cycle as DmAddr
- Start  out  1  to core; high holds the core, falling edge launches it
- Ack  in  1  core done flag (level)
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse when Result is valid
- Result  out  NUM_OUT*8  byte from OUT_BASE in the MSB position; held until the next Done
- TimedOut  out  1  sticky watchdog flag

Behaviour:
- Reset values (Reset low, immediate): state IDLE, Start=1, DmWrEn=0, DmAddr=0, DmWrData=0, Busy=0, Done=0, Result=0, TimedOut=0, counters=0.
- IDLE: Go=1 snapshots LoadData into a shift register, clears the byte counter and goes to LOAD. Start stays 1.
- LOAD, NUM_IN cycles: cycle k drives DmWrEn=1, DmAddr=IN_BASE+k, DmWrData=byte k (MSB first). After byte NUM_IN-1, go to RELEASE.
- RELEASE, 1 cycle: Start=0, DmWrEn=0. Go to WAIT_ACK.
- WAIT_ACK:
  - Arm on the first cycle Ack is sampled low.
  - Once armed, Ack=1 goes to READ. A stale high Ack left from a previous run is therefore ignored.
  - Start stays 0.
- READ, NUM_OUT cycles: DmAddr=OUT_BASE+k; DmRdData is shifted into the result shift register in the same cycle. After byte NUM_OUT-1, go to DONE.
- DONE, 1 cycle: Result <= shift register, Done=1, Start<=1 (re-parks the core). Go to IDLE.
- Latency from Go to Done: NUM_IN + 1 + (WAIT_ACK cycles) + NUM_OUT + 1.
- Go while Busy: ignored, with no queueing.
- Go in the same cycle as the Done pulse: ignored, because the state is not yet IDLE.
- Address arithmetic is mod 2^ADDR_W; base+count wraps silently.
- DmAddr returns to 0 and DmWrEn to 0 in IDLE.
- Reset asserted mid-run: immediate return to reset values. Start=1 re-parks the core, and a partial load is abandoned.
- NUM_IN=0 or NUM_OUT=0: the corresponding phase is skipped (zero cycles).

Optional Feature:
- Macro HOST_LAUNCHER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK and is cleared on entry.
  - If it reaches TIMEOUT-1 without an armed Ack, TimedOut is set (sticky until reset or the next Go). The FSM goes to DONE, skipping READ; Result is unchanged and Done still pulses.
- Undefined: no counter; WAIT_ACK waits indefinitely; TimedOut is tied 0.

Decomposition:
- Shared package host_pkg:
  - state enum typedef (IDLE, LOAD, RELEASE, WAIT_ACK, READ, DONE)
  - byte typedef
  - default IN_BASE/OUT_BASE constants, shared with the bench's DM layout
- One natural sub-module, byte_shifter: parameterized MSB-first parallel-load/serial-out and serial-in/parallel-out byte shift register, instantiated twice (load path and result path).
- FSM, counters and watchdog stay in host_launcher.

Test Plan:
1. Basic run:
   - Setup: LoadData=0x03FF_FFFB; DM model with OUT bytes 00,00,00,20; core model raises Ack 20 cycles after Start falls.
   - Expected: DM[1..4]=03,FF,FF,FB; Start falls exactly once; Result=0x0000_0020; Done is a one-cycle pulse.
2. Stale Ack:
   - Setup: Ack held 1 across Go and through RELEASE, then low 3 cycles, then high.
   - Expected: READ only after the low-then-high sequence.
3. Go spam:
   - Setup: Go asserted every cycle during a run.
   - Expected: exactly one Done; LOAD writes a single set of 4 bytes.
4. Reset mid-LOAD:
   - Setup: Reset low during byte 2.
   - Expected: Start=1, DmWrEn=0, Busy=0 immediately. A new Go rewrites all 4 bytes.
5. Timeout (HOST_LAUNCHER_TIMEOUT_EN, TIMEOUT=16):
   - Setup: Ack never rises.
   - Expected: TimedOut=1 after 16 WAIT_ACK cycles, Done pulses, Result unchanged from its previous value.
6. Wrap:
   - Setup: OUT_BASE=254, NUM_OUT=4.
   - Expected: reads at addresses 254, 255, 0, 1 in that order.

Source files
------------

// File: rtl/host_launcher_pkg.sv
// ---------------------------------------------------------------------------
// host_pkg: shared types and constants for host_launcher.
//   state_t      - launcher FSM states
//   byte_t       - one data-memory byte
//   DEF_IN_BASE  - default DM address of the first operand byte
//   DEF_OUT_BASE - default DM address of the first result byte
// The DM layout constants are also used by the testbench.
// ---------------------------------------------------------------------------
package host_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RELEASE  = 3'd2,
        WAIT_ACK = 3'd3,
        READ     = 3'd4,
        DONE     = 3'd5
    } state_t;

    typedef logic [7:0] byte_t;

    localparam int DEF_IN_BASE  = 1;
    localparam int DEF_OUT_BASE = 5;

endpackage

// File: rtl/host_launcher_if.sv
// ---------------------------------------------------------------------------
// host_launcher_if: data-memory port plus core Start/Ack handshake.
//   DmAddr/DmWrData/DmWrEn : launcher -> DM
//   DmRdData               : DM -> launcher (combinational read)
//   Start                  : launcher -> core (high parks, falling edge launches)
//   Ack                    : core -> launcher (done level)
// master = launcher side, slave = memory/core side.
// ---------------------------------------------------------------------------
interface host_launcher_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] DmAddr;
    logic [7:0]        DmWrData;
    logic              DmWrEn;
    logic [7:0]        DmRdData;
    logic              Start;
    logic              Ack;

    modport master (
        output DmAddr, DmWrData, DmWrEn, Start,
        input  DmRdData, Ack
    );

    modport slave (
        input  DmAddr, DmWrData, DmWrEn, Start,
        output DmRdData, Ack
    );
endinterface

// File: rtl/host_launcher_byte_shifter.sv
// ---------------------------------------------------------------------------
// byte_shifter: MSB-first byte shift register.
//   load/par_in     - parallel load (has priority over shift)
//   shift_en/ser_in - shift left by one byte, ser_in enters at the LSB byte
//   ser_out         - current MSB byte
//   par_q           - current contents
//   par_next        - contents after the coming clock edge
// ---------------------------------------------------------------------------
module byte_shifter
    import host_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [NBYTES*8-1:0] par_in,
    input  logic                shift_en,
    input  byte_t               ser_in,
    output byte_t               ser_out,
    output logic [NBYTES*8-1:0] par_q,
    output logic [NBYTES*8-1:0] par_next
);

    logic [NBYTES*8-1:0] data_q;
    logic [NBYTES*8-1:0] data_d;
    logic [NBYTES*8-1:0] shifted;

    if (NBYTES > 1) begin : g_multi
        assign shifted = {data_q[NBYTES*8-9:0], ser_in};
    end else begin : g_single
        assign shifted = ser_in;
    end

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = par_in;
        end else if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_out  = data_q[NBYTES*8-1 -: 8];
    assign par_q    = data_q;
    assign par_next = data_d;

endmodule

// File: rtl/host_launcher.sv
// ---------------------------------------------------------------------------
// host_launcher: initiator for the core's Start/Ack launch handshake.
// Writes NUM_IN operand bytes to DM, releases Start, waits for a fresh Ack,
// reads NUM_OUT result bytes back and pulses Done with Result valid.
//
// Ports:
//   Clk, Reset (async, active-low)
//   Go        - one-cycle run request (ignored unless idle)
//   LoadData  - operand bytes, MSB byte goes to IN_BASE
//   bus       - host_launcher_if.master (DM port + Start/Ack)
//   Busy      - high outside IDLE
//   Done      - one-cycle pulse, Result valid in the same cycle
//   Result    - result bytes, byte from OUT_BASE in the MSB position
//   TimedOut  - sticky watchdog flag
//
// Optional feature macro: HOST_LAUNCHER_TIMEOUT_EN enables the WAIT_ACK
// watchdog; without it TimedOut is tied low.
// ---------------------------------------------------------------------------
module host_launcher
    import host_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int NUM_OUT  = 4,
    parameter int IN_BASE  = DEF_IN_BASE,
    parameter int OUT_BASE = DEF_OUT_BASE,
    parameter int ADDR_W   = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Go,
    input  logic [NUM_IN*8-1:0]  LoadData,
    host_launcher_if.master      bus,
    output logic                 Busy,
    output logic                 Done,
    output logic [NUM_OUT*8-1:0] Result,
    output logic                 TimedOut
);

    localparam int IN_NB  = (NUM_IN  > 0) ? NUM_IN  : 1;
    localparam int OUT_NB = (NUM_OUT > 0) ? NUM_OUT : 1;

    if (TIMEOUT < 2) begin : g_timeout_chk
        $error("host_launcher: TIMEOUT must be at least 2");
    end

    // Base + byte index, wrapping mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] dm_addr(input int base, input logic [15:0] k);
        return ADDR_W'(base + int'(k));
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [NUM_OUT*8-1:0]  result_q, result_d;
    logic                  timed_out_q, timed_out_d;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
    logic [31:0]           wd_q, wd_d;
`endif

    logic                  ld_load, ld_shift;
    logic [IN_NB*8-1:0]    ld_par_in;
    byte_t                 ld_ser_out;
    logic [IN_NB*8-1:0]    ld_par_unused, ld_next_unused;
    logic                  rs_shift;
    byte_t                 rs_ser_unused;
    logic [OUT_NB*8-1:0]   rs_par_unused, rs_par_next;

    if (NUM_IN > 0) begin : g_ld_in
        assign ld_par_in = LoadData;
    end else begin : g_ld_none
        assign ld_par_in = '0;
    end

    byte_shifter #(.NBYTES(IN_NB)) u_load_shifter (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (ld_load),
        .par_in   (ld_par_in),
        .shift_en (ld_shift),
        .ser_in   (8'h00),
        .ser_out  (ld_ser_out),
        .par_q    (ld_par_unused),
        .par_next (ld_next_unused)
    );

    byte_shifter #(.NBYTES(OUT_NB)) u_result_shifter (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (1'b0),
        .par_in   ('0),
        .shift_en (rs_shift),
        .ser_in   (bus.DmRdData),
        .ser_out  (rs_ser_unused),
        .par_q    (rs_par_unused),
        .par_next (rs_par_next)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        result_d     = result_q;
        timed_out_d  = timed_out_q;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
        wd_d         = wd_q;
`endif
        ld_load      = 1'b0;
        ld_shift     = 1'b0;
        rs_shift     = 1'b0;
        bus.DmAddr   = '0;
        bus.DmWrData = '0;
        bus.DmWrEn   = 1'b0;
        bus.Start    = 1'b1;
        Busy         = 1'b1;
        Done         = 1'b0;

        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Go) begin
                    ld_load     = 1'b1;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = (NUM_IN > 0) ? LOAD : RELEASE;
                end
            end
            LOAD: begin
                bus.DmWrEn   = 1'b1;
                bus.DmAddr   = dm_addr(IN_BASE, cnt_q);
                bus.DmWrData = ld_ser_out;
                ld_shift     = 1'b1;
                if (cnt_q == 16'(NUM_IN - 1)) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RELEASE: begin
                bus.Start = 1'b0;
                armed_d   = 1'b0;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
                wd_d      = '0;
`endif
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                bus.Start = 1'b0;
                // Only an Ack that rises after being seen low counts, so a
                // level left over from the previous run cannot end this one.
                if (armed_q && bus.Ack) begin
                    cnt_d   = '0;
                    state_d = (NUM_OUT > 0) ? READ : DONE;
                end else begin
                    if (!bus.Ack) begin
                        armed_d = 1'b1;
                    end
`ifdef HOST_LAUNCHER_TIMEOUT_EN
                    if (wd_q == 32'(TIMEOUT - 1)) begin
                        timed_out_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
`endif
                end
            end
            READ: begin
                bus.Start  = 1'b0;
                bus.DmAddr = dm_addr(OUT_BASE, cnt_q);
                rs_shift   = 1'b1;
                if (cnt_q == 16'(NUM_OUT - 1)) begin
                    // Capture the completed shift value on entry to DONE so
                    // Result is already valid while Done is high.
                    result_d = rs_par_next[NUM_OUT*8-1:0];
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            result_q    <= '0;
            timed_out_q <= 1'b0;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            result_q    <= result_d;
            timed_out_q <= timed_out_d;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign Result = result_q;
`ifdef HOST_LAUNCHER_TIMEOUT_EN
    assign TimedOut = timed_out_q;
`else
    assign TimedOut = 1'b0;
`endif

endmodule
